// File: rtl/nonogram_phase_controller.sv
// Six-state phase controller: arbitrates the shared line FIFO, flags overflow/underflow/timeout, flushes between puzzles.
// State latency 1 cycle; FIFO strobes and data mux are combinational; no backpressure of its own (done pulses outside their state are dropped).
module nonogram_phase_controller #(
    parameter int LINE_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int FLUSH_CYCLES   = 4,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_byte_valid,
    input  logic                   parsed,
    input  logic                   solved,
    input  logic                   assembled,
    input  logic                   clear,
    input  logic                   parse_write,
    input  logic                   parse_read,
    input  logic [LINE_WIDTH-1:0]  parse_line,
    input  logic                   solve_write,
    input  logic                   solve_read,
    input  logic [LINE_WIDTH-1:0]  solve_line,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   fifo_wr_en,
    output logic                   fifo_rd_en,
    output logic [LINE_WIDTH-1:0]  fifo_din,
    output logic                   fifo_flush,
    output logic                   solve_start,
    output logic                   solve_abort,
    output logic [2:0]             state,
    output logic [1:0]             error_code,
    output logic [COUNT_WIDTH-1:0] solved_count,
    output logic [7:0]             led
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RECEIVE  = 3'd1,
        S_SOLVE    = 3'd2,
        S_TRANSMIT = 3'd3,
        S_FLUSH    = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [1:0]             err_q, err_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [FL_W-1:0]        fl_q, fl_d;
    logic                   start_q, start_d;
    logic                   wr_req, rd_req, overflow, underflow;

    always_comb begin
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        fifo_din = '0;
        case (state_q)
            S_RECEIVE: begin
                wr_req   = parse_write;
                rd_req   = parse_read;
                fifo_din = parse_line;
            end
            S_SOLVE: begin
                wr_req   = solve_write;
                rd_req   = solve_read;
                fifo_din = solve_line;
            end
            default: ;
        endcase
    end

    assign fifo_wr_en = wr_req & ~fifo_full;
    assign fifo_rd_en = rd_req & ~fifo_empty;
    // A simultaneous successful read frees a slot, so a write against a full FIFO is only dropped, not fatal.
    assign overflow   = wr_req & fifo_full & ~fifo_rd_en;
    assign underflow  = rd_req & fifo_empty;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:     if (rx_byte_valid) state_d = S_RECEIVE;
            S_RECEIVE: begin
                if (parsed)         state_d = S_SOLVE;
                else if (overflow)  begin state_d = S_ERROR; err_d = 2'd1; end
                else if (underflow) begin state_d = S_ERROR; err_d = 2'd3; end
            end
            S_SOLVE: begin
                if (solved)               state_d = S_TRANSMIT;
                else if (overflow)        begin state_d = S_ERROR; err_d = 2'd1; end
                else if (underflow)       begin state_d = S_ERROR; err_d = 2'd3; end
                else if (wd_q == WD_LAST) begin state_d = S_ERROR; err_d = 2'd2; end
            end
            S_TRANSMIT: begin
                if (assembled) begin
                    state_d = S_FLUSH;
                    if (cnt_q != {COUNT_WIDTH{1'b1}}) cnt_d = cnt_q + COUNT_WIDTH'(1);
                end
            end
            S_FLUSH:    if (fl_q == FL_LAST) state_d = S_IDLE;
            S_ERROR:    if (clear) state_d = S_FLUSH;
            default:    state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE && state_q != S_IDLE) err_d = 2'd0;
    end

    // Both counters restart from zero on every entry into their state.
    assign wd_d    = (state_q == S_SOLVE && state_d == S_SOLVE) ? wd_q + WD_W'(1) : '0;
    assign fl_d    = (state_q == S_FLUSH && state_d == S_FLUSH) ? fl_q + FL_W'(1) : '0;
    assign start_d = (state_d == S_SOLVE) && (state_q != S_SOLVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 2'd0;
            cnt_q   <= '0;
            wd_q    <= '0;
            fl_q    <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            fl_q    <= fl_d;
            start_q <= start_d;
        end
    end

    assign state        = state_q;
    assign error_code   = err_q;
    assign solved_count = cnt_q;
    assign solve_start  = start_q;
    assign solve_abort  = (state_q == S_ERROR) || (state_q == S_FLUSH);
    assign fifo_flush   = (state_q == S_FLUSH);
    assign led          = {3'(cnt_q), err_q, state_q};

endmodule

// File: tb/tb_nonogram_phase_controller.sv
// Scoreboard bench: dut_a uses a long watchdog and 8-bit count, dut_b a 10-cycle watchdog and 2-bit count.
module tb_nonogram_phase_controller;

    localparam int SIG_STATE = 0, SIG_ERR = 1, SIG_CNT = 2, SIG_WR = 3, SIG_RD = 4;
    localparam int SIG_DIN = 5, SIG_FLUSH = 6, SIG_START = 7, SIG_ABORT = 8, SIG_LED = 9;

    typedef struct {
        int    cyc;
        int    dut;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst;
    logic sel_b;
    logic rx_byte_valid, parsed, solved, assembled, clear;
    logic parse_write, parse_read, solve_write, solve_read;
    logic fifo_full, fifo_empty;
    logic [15:0] parse_line, solve_line;

    logic        a_wr, a_rd, a_flush, a_start, a_abort;
    logic [15:0] a_din;
    logic [2:0]  a_state;
    logic [1:0]  a_err;
    logic [7:0]  a_cnt, a_led;
    logic        b_wr, b_rd, b_flush, b_start, b_abort;
    logic [15:0] b_din;
    logic [2:0]  b_state;
    logic [1:0]  b_err;
    logic [1:0]  b_cnt;
    logic [7:0]  b_led;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nonogram_phase_controller #(.LINE_WIDTH(16), .TIMEOUT_CYCLES(100), .FLUSH_CYCLES(4), .COUNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .rx_byte_valid(rx_byte_valid & ~sel_b), .parsed(parsed & ~sel_b),
        .solved(solved & ~sel_b), .assembled(assembled & ~sel_b), .clear(clear & ~sel_b),
        .parse_write(parse_write & ~sel_b), .parse_read(parse_read & ~sel_b), .parse_line(parse_line),
        .solve_write(solve_write & ~sel_b), .solve_read(solve_read & ~sel_b), .solve_line(solve_line),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(a_wr), .fifo_rd_en(a_rd), .fifo_din(a_din), .fifo_flush(a_flush),
        .solve_start(a_start), .solve_abort(a_abort), .state(a_state), .error_code(a_err),
        .solved_count(a_cnt), .led(a_led)
    );

    nonogram_phase_controller #(.LINE_WIDTH(16), .TIMEOUT_CYCLES(10), .FLUSH_CYCLES(4), .COUNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst),
        .rx_byte_valid(rx_byte_valid & sel_b), .parsed(parsed & sel_b),
        .solved(solved & sel_b), .assembled(assembled & sel_b), .clear(clear & sel_b),
        .parse_write(parse_write & sel_b), .parse_read(parse_read & sel_b), .parse_line(parse_line),
        .solve_write(solve_write & sel_b), .solve_read(solve_read & sel_b), .solve_line(solve_line),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(b_wr), .fifo_rd_en(b_rd), .fifo_din(b_din), .fifo_flush(b_flush),
        .solve_start(b_start), .solve_abort(b_abort), .state(b_state), .error_code(b_err),
        .solved_count(b_cnt), .led(b_led)
    );

    function automatic int getv(input int d, input int s);
        int v;
        v = -1;
        case (s)
            SIG_STATE: v = (d == 0) ? int'(a_state) : int'(b_state);
            SIG_ERR:   v = (d == 0) ? int'(a_err)   : int'(b_err);
            SIG_CNT:   v = (d == 0) ? int'(a_cnt)   : int'(b_cnt);
            SIG_WR:    v = (d == 0) ? int'(a_wr)    : int'(b_wr);
            SIG_RD:    v = (d == 0) ? int'(a_rd)    : int'(b_rd);
            SIG_DIN:   v = (d == 0) ? int'(a_din)   : int'(b_din);
            SIG_FLUSH: v = (d == 0) ? int'(a_flush) : int'(b_flush);
            SIG_START: v = (d == 0) ? int'(a_start) : int'(b_start);
            SIG_ABORT: v = (d == 0) ? int'(a_abort) : int'(b_abort);
            SIG_LED:   v = (d == 0) ? int'(a_led)   : int'(b_led);
            default:   v = -1;
        endcase
        return v;
    endfunction

    // Monitor: compares every expectation due in the current cycle, half a cycle after the edge.
    always @(negedge clk) begin : monitor
        int i;
        int got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                got = getv(sb[i].dut, sb[i].sig);
                checks++;
                if (got != sb[i].val) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d",
                             sb[i].name, sb[i].dut, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s dut%0d: expectation for cycle %0d never sampled", sb[i].name, sb[i].dut, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push(input int d, input int off, input int s, input int v, input string n);
        exp_t e;
        e.cyc  = cyc + off;
        e.dut  = d;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_byte_valid = 0; parsed = 0; solved = 0; assembled = 0; clear = 0;
        parse_write = 0; parse_read = 0; solve_write = 0; solve_read = 0;
        fifo_full = 0; fifo_empty = 0;
    endtask

    // Called on the first FLUSH cycle; returns on the first IDLE cycle.
    task automatic flush_to_idle(input int d, input int err_during);
        for (int k = 0; k < 4; k++) begin
            push(d, 0, SIG_STATE, 4, "flush_state");
            push(d, 0, SIG_FLUSH, 1, "flush_hi");
            push(d, 0, SIG_ABORT, 1, "flush_abort");
            push(d, 0, SIG_ERR, err_during, "flush_err_hold");
            tick();
        end
        push(d, 0, SIG_STATE, 0, "flush_done_idle");
        push(d, 0, SIG_FLUSH, 0, "flush_released");
        push(d, 0, SIG_ERR, 0, "err_cleared_idle");
    endtask

    task automatic to_solve(input int d);
        rx_byte_valid = 1; push(d, 1, SIG_STATE, 1, "enter_receive"); tick(); rx_byte_valid = 0;
        parsed = 1; push(d, 1, SIG_STATE, 2, "enter_solve"); push(d, 1, SIG_START, 1, "start_pulse");
        tick(); parsed = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel_b = 0;
        idle_inputs();
        parse_line = 16'h0;
        solve_line = 16'h0;
        rst = 1;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            push(d, 0, SIG_STATE, 0, "rst_state");  push(d, 0, SIG_ERR, 0, "rst_err");
            push(d, 0, SIG_CNT, 0, "rst_cnt");      push(d, 0, SIG_LED, 0, "rst_led");
            push(d, 0, SIG_START, 0, "rst_start");  push(d, 0, SIG_FLUSH, 0, "rst_flush");
            push(d, 0, SIG_WR, 0, "rst_wr");        push(d, 0, SIG_RD, 0, "rst_rd");
            push(d, 0, SIG_ABORT, 0, "rst_abort");
        end
        rst = 0;
        tick();

        parsed = 1; solved = 1; assembled = 1; clear = 1;
        push(0, 1, SIG_STATE, 0, "stray_pulses_idle");
        tick(); idle_inputs();

        // Full puzzle on dut_a
        rx_byte_valid = 1; push(0, 1, SIG_STATE, 1, "idle_to_receive"); tick(); rx_byte_valid = 0;
        for (int i = 0; i < 22; i++) begin
            parse_write = 1;
            parse_line  = 16'(16'hA000 + i);
            push(0, 0, SIG_WR, 1, "parse_wr_en");
            push(0, 0, SIG_DIN, int'(parse_line), "parse_din");
            push(0, 0, SIG_STATE, 1, "receive_hold");
            tick();
        end
        parsed = 1; parse_write = 1; fifo_full = 1;
        push(0, 0, SIG_WR, 0, "full_write_gated");
        push(0, 1, SIG_STATE, 2, "parsed_beats_overflow");
        push(0, 1, SIG_START, 1, "solve_start_first");
        push(0, 1, SIG_LED, 8'h02, "led_solve");
        tick(); idle_inputs();
        for (int i = 0; i < 22; i++) begin
            solve_write = 1; solve_read = 1;
            solve_line  = 16'(16'h5000 + i);
            push(0, 0, SIG_WR, 1, "solve_wr_en");
            push(0, 0, SIG_RD, 1, "solve_rd_en");
            push(0, 0, SIG_DIN, int'(solve_line), "solve_din");
            push(0, 0, SIG_STATE, 2, "solve_hold");
            if (i > 0) push(0, 0, SIG_START, 0, "solve_start_once");
            tick();
        end
        idle_inputs();
        solved = 1; push(0, 1, SIG_STATE, 3, "solve_to_transmit"); tick(); solved = 0;
        parse_write = 1; parse_read = 1; solve_write = 1; solve_read = 1; parse_line = 16'hFFFF;
        push(0, 0, SIG_WR, 0, "transmit_wr_zero");
        push(0, 0, SIG_RD, 0, "transmit_rd_zero");
        push(0, 0, SIG_DIN, 0, "transmit_din_zero");
        push(0, 0, SIG_STATE, 3, "transmit_hold");
        tick(); idle_inputs();
        assembled = 1;
        push(0, 1, SIG_STATE, 4, "transmit_to_flush");
        push(0, 1, SIG_CNT, 1, "count_one");
        tick(); assembled = 0;
        flush_to_idle(0, 0);
        push(0, 0, SIG_LED, 8'h20, "led_idle_count1");

        // Overflow in RECEIVE
        rx_byte_valid = 1; tick(); rx_byte_valid = 0;
        parse_write = 1; fifo_full = 1;
        push(0, 0, SIG_WR, 0, "ovf_wr_gated");
        push(0, 1, SIG_STATE, 5, "ovf_error");
        push(0, 1, SIG_ERR, 1, "ovf_code");
        push(0, 1, SIG_ABORT, 1, "ovf_abort");
        push(0, 1, SIG_LED, 8'h2D, "ovf_led");
        tick(); idle_inputs();
        rx_byte_valid = 1; push(0, 1, SIG_STATE, 5, "error_holds"); tick(); rx_byte_valid = 0;
        clear = 1; push(0, 1, SIG_STATE, 4, "clear_to_flush"); tick(); clear = 0;
        flush_to_idle(0, 1);

        // SOLVE: read frees a slot, then underflow
        to_solve(0);
        solve_write = 1; solve_read = 1; fifo_full = 1;
        push(0, 0, SIG_WR, 0, "full_rw_wr_gated");
        push(0, 0, SIG_RD, 1, "full_rw_rd_ok");
        push(0, 1, SIG_STATE, 2, "full_rw_no_error");
        tick(); idle_inputs();
        solve_read = 1; fifo_empty = 1;
        push(0, 0, SIG_RD, 0, "unf_rd_gated");
        push(0, 1, SIG_STATE, 5, "unf_error");
        push(0, 1, SIG_ERR, 3, "unf_code");
        tick(); idle_inputs();
        clear = 1; push(0, 1, SIG_STATE, 4, "unf_clear_flush"); tick(); clear = 0;
        flush_to_idle(0, 3);

        // Watchdog on dut_b
        sel_b = 1;
        to_solve(1);
        for (int k = 0; k < 10; k++) begin
            push(1, 0, SIG_STATE, 2, "wd_in_solve");
            tick();
        end
        push(1, 0, SIG_STATE, 5, "wd_error");
        push(1, 0, SIG_ERR, 2, "wd_code");
        push(1, 0, SIG_ABORT, 1, "wd_abort");
        clear = 1; push(1, 1, SIG_STATE, 4, "wd_clear_flush"); tick(); clear = 0;
        flush_to_idle(1, 2);

        to_solve(1);
        for (int k = 0; k < 9; k++) begin
            push(1, 0, SIG_STATE, 2, "wd_edge_solve");
            tick();
        end
        solved = 1; push(1, 1, SIG_STATE, 3, "wd_last_cycle_solved"); tick(); solved = 0;
        assembled = 1; push(1, 1, SIG_CNT, 1, "b_count1"); tick(); assembled = 0;
        flush_to_idle(1, 0);

        // Saturation of the 2-bit counter
        for (int p = 2; p <= 4; p++) begin
            to_solve(1);
            solved = 1; tick(); solved = 0;
            assembled = 1; push(1, 1, SIG_CNT, (p > 3) ? 3 : p, "b_count_sat"); tick(); assembled = 0;
            flush_to_idle(1, 0);
        end
        push(1, 0, SIG_LED, 8'h60, "b_led_sat");

        // Asynchronous reset in the middle of SOLVE
        to_solve(1);
        push(1, 0, SIG_STATE, 2, "pre_rst_solve");
        tick();
        rst = 1;
        push(1, 0, SIG_STATE, 0, "arst_state");
        push(1, 0, SIG_LED, 0, "arst_led");
        push(1, 0, SIG_CNT, 0, "arst_cnt");
        push(1, 0, SIG_ABORT, 0, "arst_no_flush");
        push(0, 0, SIG_CNT, 0, "arst_cnt_a");
        tick();
        rst = 0;
        tick();
        push(1, 0, SIG_STATE, 0, "post_rst_idle");
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
